// File: rtl/stage_alu_mul_ctrl_pkg.sv
// Shared definitions for the stage_alu multiply sequencer.
//   - instruction field widths and the RV32 encodings the decoder compares against
//   - default multiplier latency
//   - sequencer state enum (also exported on the debug state port)
package stage_alu_mul_ctrl_pkg;

    localparam int OPCODE_SIZE    = 7;
    localparam int FUNCT7_SIZE    = 7;
    localparam int FUNCT3_SIZE    = 3;
    localparam int INSTR_REG_SIZE = 5;

    localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = 7'b0110011;
    localparam logic [OPCODE_SIZE-1:0] OPCODE_IM = 7'b0010011;

    localparam logic [FUNCT7_SIZE-1:0] F7_ADD    = 7'b0000000;
    localparam logic [FUNCT7_SIZE-1:0] F7_SUB    = 7'b0100000;
    localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = 7'b0000001;

    localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;

    // Cycles from the launch pulse to a valid multiplier output.
    localparam int DEFAULT_MUL_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_ctrl_state_t;

endpackage

// File: rtl/stage_alu_mul_ctrl.sv
// Multiply sequencer for the ALU stage.
// Decodes the ALU-stage instruction, launches the fixed-latency multiplier on
// MUL, stalls upstream until the product is ready, then steers the multiplier
// output onto alu_result and marks it valid for the downstream latch.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   valid_i           ALU-stage register holds a real instruction
//   opcode_i/funct7_i/funct3_i/rd_i   fields of the ALU-stage instruction
//   mem_stall_i       downstream cannot take a result this cycle
//   flush_i           kill the ALU-stage instruction (redirect)
//   stall_o           hold PC, IF/ID and ID/ALU registers
//   mul_start_o       one-cycle launch pulse to the multiplier
//   mul_busy_o        multiplier occupied (BUSY or DONE)
//   mul_sel_o         alu_result mux selects the multiplier output
//   result_valid_o    multiplier result valid this cycle
//   rd_o              destination register of the completing multiply (0 otherwise)
//   illegal_o         unsupported OPCODE_OP/F7_MULDIV encoding seen
//   state_o           current sequencer state (debug)
//
// Handshake: an instruction is consumed from the ALU stage on any clock edge
// where valid_i=1 and stall_o=0 (stall_o acts as the inverse of ready). A result
// is handed downstream on any edge where result_valid_o=1 and mem_stall_i=0;
// while mem_stall_i holds, result_valid_o, mul_sel_o and rd_o stay stable.
module stage_alu_mul_ctrl
    import stage_alu_mul_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_i,
    input  logic [OPCODE_SIZE-1:0]    opcode_i,
    input  logic [FUNCT7_SIZE-1:0]    funct7_i,
    input  logic [FUNCT3_SIZE-1:0]    funct3_i,
    input  logic [INSTR_REG_SIZE-1:0] rd_i,
    input  logic                      mem_stall_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      mul_start_o,
    output logic                      mul_busy_o,
    output logic                      mul_sel_o,
    output logic                      result_valid_o,
    output logic [INSTR_REG_SIZE-1:0] rd_o,
    output logic                      illegal_o,
    output mul_ctrl_state_t           state_o
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    mul_ctrl_state_t           state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [INSTR_REG_SIZE-1:0] rd_q, rd_next;
    logic                      is_muldiv, is_mul, is_bad;

    assign is_muldiv = valid_i && (opcode_i == OPCODE_OP) && (funct7_i == F7_MULDIV);
    assign is_mul    = is_muldiv && (funct3_i == F3_MUL);
    assign is_bad    = is_muldiv && (funct3_i != F3_MUL);

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rd_q  <= rd_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rd_next        = rd_q;
        stall_o        = 1'b0;
        mul_start_o    = 1'b0;
        mul_busy_o     = 1'b0;
        mul_sel_o      = 1'b0;
        result_valid_o = 1'b0;
        rd_o           = '0;
        illegal_o      = 1'b0;

        case (state)
            IDLE: begin
                if (is_mul && !flush_i) begin
                    mul_start_o = 1'b1;
                    stall_o     = 1'b1;
                    rd_next     = rd_i;
                    cnt_next    = CNT_W'(MUL_LATENCY - 1);
                    // A single-cycle multiplier has no BUSY phase at all.
                    state_next  = (MUL_LATENCY > 1) ? BUSY : DONE;
                end
                // Bad encodings flow through as a nop; decode already
                // suppresses the register write, so no stall here.
                illegal_o = is_bad && !flush_i;
            end

            BUSY: begin
                stall_o    = 1'b1;
                mul_busy_o = 1'b1;
                // The multiplier is free-running, so count down even while
                // downstream is stalled.
                cnt_next   = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                mul_busy_o = 1'b1;
                stall_o    = mem_stall_i;
                if (!flush_i) begin
                    mul_sel_o      = 1'b1;
                    result_valid_o = 1'b1;
                    rd_o           = rd_q;
                end
                // Leaving DONE coincides with the ALU-stage register advancing,
                // so the completed MUL cannot be seen again in IDLE.
                if (!mem_stall_i) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush overrides every state transition; the in-flight product is dropped.
        if (flush_i) begin
            state_next = IDLE;
            cnt_next   = '0;
        end

        // Outputs are forced quiet for the whole reset window, including a
        // reset that lands mid-operation.
        if (reset) begin
            stall_o        = 1'b0;
            mul_start_o    = 1'b0;
            mul_busy_o     = 1'b0;
            mul_sel_o      = 1'b0;
            result_valid_o = 1'b0;
            rd_o           = '0;
            illegal_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_alu_mul_ctrl.sv
module tb_stage_alu_mul_ctrl;
    import stage_alu_mul_ctrl_pkg::*;

    localparam int L = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset = 1'b1;
    logic                      valid_i = 1'b0;
    logic [OPCODE_SIZE-1:0]    opcode_i = '0;
    logic [FUNCT7_SIZE-1:0]    funct7_i = '0;
    logic [FUNCT3_SIZE-1:0]    funct3_i = '0;
    logic [INSTR_REG_SIZE-1:0] rd_i = '0;
    logic                      mem_stall_i = 1'b0;
    logic                      flush_i = 1'b0;
    logic                      stall_o, mul_start_o, mul_busy_o, mul_sel_o;
    logic                      result_valid_o, illegal_o;
    logic [INSTR_REG_SIZE-1:0] rd_o;
    mul_ctrl_state_t           state_o;

    stage_alu_mul_ctrl #(.MUL_LATENCY(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .opcode_i       (opcode_i),
        .funct7_i       (funct7_i),
        .funct3_i       (funct3_i),
        .rd_i           (rd_i),
        .mem_stall_i    (mem_stall_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .mul_start_o    (mul_start_o),
        .mul_busy_o     (mul_busy_o),
        .mul_sel_o      (mul_sel_o),
        .result_valid_o (result_valid_o),
        .rd_o           (rd_o),
        .illegal_o      (illegal_o),
        .state_o        (state_o)
    );

    // {stall, start, busy, sel, valid, rd[4:0], illegal}
    logic [10:0] obs;
    assign obs = {stall_o, mul_start_o, mul_busy_o, mul_sel_o, result_valid_o, rd_o, illegal_o};

    int checks = 0;
    int errors = 0;
    logic [INSTR_REG_SIZE-1:0] exp_q[$];

    function automatic logic [10:0] mk(input logic s, input logic st, input logic b,
                                       input logic sl, input logic v,
                                       input logic [4:0] r, input logic il);
        return {s, st, b, sl, v, r, il};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the following falling edge.
    task automatic drive(input logic rst, input logic v, input logic [6:0] op,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [4:0] rd, input logic ms, input logic fl);
        @(posedge clk);
        #1;
        reset       = rst;
        valid_i     = v;
        opcode_i    = op;
        funct7_i    = f7;
        funct3_i    = f3;
        rd_i        = rd;
        mem_stall_i = ms;
        flush_i     = fl;
        @(negedge clk);
    endtask

    task automatic drive_mul(input logic [4:0] rd, input logic ms, input logic fl);
        drive(1'b0, 1'b1, OPCODE_OP, F7_MULDIV, F3_MUL, rd, ms, fl);
    endtask

    task automatic drive_nop();
        drive(1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [10:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, OPCODE_OP, F7_MULDIV, F3_MUL, 5'd4, 1'b0, 1'b0);
            checks++;
            if (obs !== 11'd0 || state_o !== IDLE) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b state %0d, expected 0 state IDLE", i, obs, state_o);
            end
        end
        // First MUL after release starts normally and completes.
        for (int i = 0; i <= L; i++) begin
            drive_mul(5'd4, 1'b0, 1'b0);
            if (i == 0)      exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
            else if (i < L)  exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
            else             exp = mk(0, 0, 1, 1, 1, 5'd4, 0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL post_reset_mul cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
        drive_nop();
    endtask

    task automatic test_single();
        logic [10:0] exp;
        for (int i = 0; i <= L + 1; i++) begin
            if (i <= L) drive_mul(5'd5, 1'b0, 1'b0);
            else        drive_nop();
            if (i == 0)      exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
            else if (i < L)  exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
            else if (i == L) exp = mk(0, 0, 1, 1, 1, 5'd5, 0);
            else             exp = 11'd0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_non_mul();
        drive(1'b0, 1'b1, OPCODE_IM, F7_MULDIV, F3_MUL, 5'd6, 1'b0, 1'b0);
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL non_mul_im: got %b expected %b", obs, 11'd0);
        end
        drive(1'b0, 1'b1, OPCODE_OP, F7_SUB, F3_MUL, 5'd6, 1'b0, 1'b0);
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL non_mul_sub: got %b expected %b", obs, 11'd0);
        end
        drive(1'b0, 1'b1, OPCODE_OP, F7_MULDIV, 3'b111, 5'd6, 1'b0, 1'b0);
        checks++;
        if (obs !== mk(0, 0, 0, 0, 0, 5'd0, 1)) begin
            errors++;
            $display("FAIL non_mul_illegal: got %b expected %b", obs, mk(0, 0, 0, 0, 0, 5'd0, 1));
        end
        drive_nop();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL illegal_one_cycle: got %b expected %b", obs, 11'd0);
        end
    endtask

    task automatic test_mem_stall();
        logic [10:0] exp;
        for (int i = 0; i <= 9; i++) begin
            if (i <= 8) drive_mul(5'd9, (i >= 5 && i <= 7), 1'b0);
            else        drive_nop();
            if (i == 0)      exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
            else if (i < 5)  exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
            else if (i < 8)  exp = mk(1, 0, 1, 1, 1, 5'd9, 0);
            else if (i == 8) exp = mk(0, 0, 1, 1, 1, 5'd9, 0);
            else             exp = 11'd0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mem_stall cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [10:0] exp;
        for (int i = 0; i <= 9; i++) begin
            if (i <= 2) drive_mul(5'd12, 1'b0, (i == 2));
            else        drive_nop();
            if (i == 0)     exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
            else if (i < 3) exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
            else            exp = 11'd0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL flush cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        logic [4:0]  want;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        for (int i = 0; i <= 12; i++) begin
            if (i <= 5)       drive_mul(5'd3, 1'b0, 1'b0);
            else if (i <= 11) drive_mul(5'd7, 1'b0, 1'b0);
            else              drive_nop();
            if (i == 0 || i == 6)      exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
            else if (i == 5)           exp = mk(0, 0, 1, 1, 1, 5'd3, 0);
            else if (i == 11)          exp = mk(0, 0, 1, 1, 1, 5'd7, 0);
            else if (i == 12)          exp = 11'd0;
            else                       exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs, exp);
            end
            // Scoreboard: every result accepted downstream must match the next expected rd.
            if (result_valid_o === 1'b1 && mem_stall_i == 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_scoreboard cyc%0d: got rd %0d, expected no result", i, rd_o);
                end else begin
                    want = exp_q.pop_front();
                    if (rd_o !== want) begin
                        errors++;
                        $display("FAIL b2b_scoreboard cyc%0d: got rd %0d expected %0d", i, rd_o, want);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Transaction-level reference: a MUL accepted at cycle t0 is "computing"
    // while now-t0 < L and "completed" afterwards until downstream takes it.
    task automatic test_random();
        bit          m_active = 1'b0;
        int          m_t0 = 0;
        logic [4:0]  m_rd = '0;
        logic [10:0] exp;
        logic        r_rst, r_v, r_ms, r_fl, r_mul, r_bad;
        logic [6:0]  r_op, r_f7;
        logic [2:0]  r_f3;
        logic [4:0]  r_rd;
        for (int now = 0; now < 600; now++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_v   = ($urandom_range(0, 3) != 0);
            r_op  = ($urandom_range(0, 3) != 0) ? OPCODE_OP : OPCODE_IM;
            case ($urandom_range(0, 3))
                0:       r_f7 = F7_SUB;
                1:       r_f7 = F7_ADD;
                default: r_f7 = F7_MULDIV;
            endcase
            r_f3  = ($urandom_range(0, 1) != 0) ? F3_MUL : 3'($urandom_range(0, 7));
            r_rd  = 5'($urandom_range(0, 31));
            r_ms  = ($urandom_range(0, 3) == 0);
            r_fl  = ($urandom_range(0, 99) < 5);
            drive(r_rst, r_v, r_op, r_f7, r_f3, r_rd, r_ms, r_fl);

            r_mul = r_v && r_op == OPCODE_OP && r_f7 == F7_MULDIV && r_f3 == F3_MUL;
            r_bad = r_v && r_op == OPCODE_OP && r_f7 == F7_MULDIV && r_f3 != F3_MUL;
            exp = 11'd0;
            if (r_rst) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (!r_fl && r_mul) begin
                    exp = mk(1, 1, 0, 0, 0, 5'd0, 0);
                    m_active = 1'b1;
                    m_t0 = now;
                    m_rd = r_rd;
                end else if (!r_fl && r_bad) begin
                    exp = mk(0, 0, 0, 0, 0, 5'd0, 1);
                end
            end else if (now - m_t0 < L) begin
                exp = mk(1, 0, 1, 0, 0, 5'd0, 0);
                if (r_fl) m_active = 1'b0;
            end else if (r_fl) begin
                exp = mk(r_ms, 0, 1, 0, 0, 5'd0, 0);
                m_active = 1'b0;
            end else begin
                exp = mk(r_ms, 0, 1, 1, 1, m_rd, 0);
                if (!r_ms) m_active = 1'b0;
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b", now, obs, exp);
            end
        end
        drive(1'b1, 1'b0, 7'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0);
        drive_nop();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_non_mul();
        test_mem_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
